// File: rtl/chg_entry_fifo_if.sv
// Record handshake bundle between the change-list reader and the Y-update design.
// The slave modport is the FIFO's view; the master modport is the producer/consumer side.
interface chg_entry_fifo_if;
   logic        in_valid;
   logic [15:0] in_row;
   logic [15:0] in_col;
   logic [23:0] in_real;
   logic [23:0] in_img;
   logic        in_ready;

   logic        out_valid;
   logic [15:0] out_row;
   logic [15:0] out_col;
   logic [23:0] out_real;
   logic [23:0] out_img;
   logic        out_ready;

   modport slave (
      input  in_valid, in_row, in_col, in_real, in_img, out_ready,
      output in_ready, out_valid, out_row, out_col, out_real, out_img
   );

   modport master (
      output in_valid, in_row, in_col, in_real, in_img, out_ready,
      input  in_ready, out_valid, out_row, out_col, out_real, out_img
   );
endinterface

// File: rtl/chg_entry_fifo.sv
// Show-ahead circular FIFO of change records, dropping all-zero deltas and
// tracking the end-of-list marker through a FILL/DRAIN/DONE control FSM.
module chg_entry_fifo #(
   parameter int unsigned DEPTH   = 8,
   parameter logic [15:0] EOL_ROW = 16'hFFFF
) (
   input  logic                     clock,
   input  logic                     reset,
   chg_entry_fifo_if.slave          bus,
   input  logic                     start,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              zero_drops
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     level_q, level_d;
   logic [15:0]     zero_drops_q, zero_drops_d;
   logic [79:0]     mem [DEPTH];

   logic push, pop, is_eol, is_zero, store, drop;

   // Handshake and datapath next-state
   always_comb begin
      push     = bus.in_valid && bus.in_ready;
      pop      = bus.out_valid && bus.out_ready;
      is_eol   = (bus.in_row == EOL_ROW);
      is_zero  = (bus.in_real == '0) && (bus.in_img == '0);
      store    = push && !is_eol && !is_zero;
      drop     = push && !is_eol && is_zero;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (store) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

      level_d = level_q;
      case ({store, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      zero_drops_d = zero_drops_q;
      if (drop && (zero_drops_q != '1)) zero_drops_d = zero_drops_q + 1'b1;
   end

   // EOL decisions look at the post-edge level so a concurrent pop is honoured
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:    if (push && is_eol) state_d = (level_d != '0) ? DRAIN : DONE;
         DRAIN:   if (level_d == '0) state_d = DONE;
         DONE:    if (start) state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   always_comb begin
      bus.in_ready  = (level_q != FULL_LVL) && (state_q == FILL);
      bus.out_valid = (level_q != '0);
      {bus.out_row, bus.out_col, bus.out_real, bus.out_img} =
         bus.out_valid ? mem[rd_ptr_q] : '0;
      done       = (state_q == DONE);
      level      = level_q;
      zero_drops = zero_drops_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= FILL;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         zero_drops_q <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         zero_drops_q <= zero_drops_d;
      end
   end

   always_ff @(posedge clock) begin
      if (store) mem[wr_ptr_q] <= {bus.in_row, bus.in_col, bus.in_real, bus.in_img};
   end

endmodule
